// File: rtl/uart_test_sequencer.sv
// Sequences UART self-test channels one at a time in index order, bounding each
// with a cycle timeout, spacing them with a quiesce gap and aggregating verdicts.
module uart_test_sequencer #(
    parameter int unsigned NUM_TESTS      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned IDX_W          = ($clog2(NUM_TESTS + 1) > 1) ? $clog2(NUM_TESTS + 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 stop_on_fail_i,
    input  logic [NUM_TESTS-1:0] test_enable_i,
    input  logic [NUM_TESTS-1:0] test_done_i,
    input  logic [NUM_TESTS-1:0] test_pass_i,
    output logic [NUM_TESTS-1:0] test_start_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 aborted_o,
    output logic [IDX_W-1:0]     cur_test_o,
    output logic [NUM_TESTS-1:0] ran_mask_o,
    output logic [NUM_TESTS-1:0] fail_mask_o,
    output logic [NUM_TESTS-1:0] timeout_mask_o
);

    localparam int unsigned TMR_W = ($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned GAP_W = ($clog2(GAP_CYCLES + 1) > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_LAUNCH,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     cur_q, cur_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [NUM_TESTS-1:0] en_q, en_d;
    logic [NUM_TESTS-1:0] ran_q, ran_d;
    logic [NUM_TESTS-1:0] fail_q, fail_d;
    logic [NUM_TESTS-1:0] tmo_q, tmo_d;
    logic [NUM_TESTS-1:0] start_q, start_d;
    logic                 sof_q, sof_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 abort_q, abort_d;

    logic [NUM_TESTS-1:0] cur_oh_c;
    logic                 result_c;
    logic                 failed_c;

    // One-hot of the selected channel; only used while cur_q < NUM_TESTS.
    assign cur_oh_c = NUM_TESTS'(1) << cur_q;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        timer_d  = timer_q;
        gap_d    = gap_q;
        en_d     = en_q;
        ran_d    = ran_q;
        fail_d   = fail_q;
        tmo_d    = tmo_q;
        sof_d    = sof_q;
        abort_d  = abort_q;
        start_d  = '0;
        result_c = 1'b0;
        failed_c = 1'b0;

        if (abort_i && (state_q inside {S_SELECT, S_LAUNCH, S_WAIT, S_GAP})) begin
            state_d = S_DONE;
            abort_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_d = S_SELECT;
                        en_d    = test_enable_i;
                        sof_d   = stop_on_fail_i;
                        ran_d   = '0;
                        fail_d  = '0;
                        tmo_d   = '0;
                        abort_d = 1'b0;
                        cur_d   = '0;
                    end
                end
                S_SELECT: begin
                    if (cur_q == IDX_W'(NUM_TESTS)) begin
                        state_d = S_DONE;
                    end else if (|(en_q & cur_oh_c)) begin
                        state_d = S_LAUNCH;
                        start_d = cur_oh_c;
                        ran_d   = ran_q | cur_oh_c;
                    end else begin
                        cur_d = cur_q + IDX_W'(1);
                    end
                end
                S_LAUNCH: begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end
                S_WAIT: begin
                    // A done in the timeout cycle still counts as a real result.
                    if (|(test_done_i & cur_oh_c)) begin
                        result_c = 1'b1;
                        failed_c = ~|(test_pass_i & cur_oh_c);
                    end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        result_c = 1'b1;
                        failed_c = 1'b1;
                        tmo_d    = tmo_q | cur_oh_c;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                    if (result_c) begin
                        if (failed_c) begin
                            fail_d = fail_q | cur_oh_c;
                        end
                        if (failed_c && sof_q) begin
                            state_d = S_DONE;
                        end else if (GAP_CYCLES == 0) begin
                            state_d = S_SELECT;
                            cur_d   = cur_q + IDX_W'(1);
                        end else begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                        state_d = S_SELECT;
                        cur_d   = cur_q + IDX_W'(1);
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = state_d inside {S_SELECT, S_LAUNCH, S_WAIT, S_GAP};
        done_d = (state_d == S_DONE);
        pass_d = done_d && (|ran_d) && !(|fail_d) && !abort_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            timer_q <= '0;
            gap_q   <= '0;
            en_q    <= '0;
            ran_q   <= '0;
            fail_q  <= '0;
            tmo_q   <= '0;
            start_q <= '0;
            sof_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            timer_q <= timer_d;
            gap_q   <= gap_d;
            en_q    <= en_d;
            ran_q   <= ran_d;
            fail_q  <= fail_d;
            tmo_q   <= tmo_d;
            start_q <= start_d;
            sof_q   <= sof_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            abort_q <= abort_d;
        end
    end

    assign test_start_o   = start_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign pass_o         = pass_q;
    assign aborted_o      = abort_q;
    assign cur_test_o     = cur_q;
    assign ran_mask_o     = ran_q;
    assign fail_mask_o    = fail_q;
    assign timeout_mask_o = tmo_q;

endmodule

// File: doc/uart_test_sequencer.md
Name: uart_test_sequencer

Overview:
- Synthesisable, parametrised test-campaign sequencer for UART self-test.
- Launches up to NUM_TESTS test channels one at a time, in index order. Typical channels: TX, top loopback, baud generator, FIFO BIST engines.
- Bounds each test with a cycle timeout and inserts a quiesce gap between tests.
- Aggregates pass, fail and timeout results. Supports a run-all mode and a stop-on-first-fail mode.

Parameters:
- NUM_TESTS, 4, number of test channels (1..32).
- TIMEOUT_CYCLES, 1000, maximum WAIT cycles allowed per test (>=1).
- GAP_CYCLES, 16, idle cycles between tests (0 allowed).
- IDX_W, max(1,$clog2(NUM_TESTS+1)), test index width (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  starts a campaign; honoured only in IDLE or DONE.
- abort_i  in  1  terminates the running campaign.
- stop_on_fail_i  in  1  mode select, sampled at start.
- test_enable_i  in  NUM_TESTS  channel enable mask, sampled at start.
- test_done_i  in  NUM_TESTS  per-channel completion pulse or level.
- test_pass_i  in  NUM_TESTS  per-channel result; valid with test_done_i.
- test_start_o  out  NUM_TESTS  one-hot, single-cycle launch pulse.
- busy_o  out  1  campaign in progress.
- done_o  out  1  campaign finished; held until the next start or rst.
- pass_o  out  1  final verdict; valid while done_o=1.
- aborted_o  out  1  campaign ended by abort.
- cur_test_o  out  IDX_W  index currently selected or running.
- ran_mask_o  out  NUM_TESTS  channels actually launched.
- fail_mask_o  out  NUM_TESTS  channels that failed or timed out.
- timeout_mask_o  out  NUM_TESTS  channels that timed out.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; every output and mask 0; cur_test_o=0; enable and mode latches cleared. Reset mid-campaign abandons it immediately, with no further start pulses.
- States: IDLE, SELECT, LAUNCH, WAIT, GAP, DONE.
- IDLE/DONE + start_i:
  - Next cycle: SELECT.
  - Latch test_enable_i and stop_on_fail_i.
  - Clear all masks, done_o, pass_o and aborted_o.
  - cur_test_o=0; busy_o=1.
  - start_i in any other state is ignored.
- SELECT: examines one index per cycle.
  - cur_test_o==NUM_TESTS -> DONE.
  - Latched enable bit set -> LAUNCH.
  - Otherwise cur_test_o++ and stay in SELECT.
- LAUNCH: exactly one cycle.
  - test_start_o[cur]=1, all other bits 0.
  - Set ran_mask[cur]; clear timer; go to WAIT.
- WAIT:
  - Only test_done_i[cur] is sampled; done bits of other channels are ignored. done_i is not sampled during LAUNCH.
  - Timer increments each WAIT cycle.
  - If done_i[cur]=1: test fails iff pass_i[cur]=0; fail_mask[cur] is set on failure.
  - Else if timer==TIMEOUT_CYCLES-1: timeout, i.e. exactly TIMEOUT_CYCLES WAIT cycles without done. Set timeout_mask[cur] and fail_mask[cur].
  - Done and timeout in the same cycle: done wins.
  - On a test result, exit: failure with stop_on_fail latched -> DONE; otherwise -> GAP.
- GAP:
  - Holds GAP_CYCLES cycles, then cur_test_o++ and goes to SELECT.
  - GAP_CYCLES=0 -> increment and go to SELECT in the same cycle WAIT exits.
- DONE:
  - busy_o=0, done_o=1.
  - pass_o = (ran_mask!=0) && (fail_mask==0) && !aborted_o. An empty campaign is not a pass.
  - Masks and cur_test_o hold their final values.
- abort_i in SELECT, LAUNCH, WAIT or GAP:
  - DONE next cycle; aborted_o=1; pass_o=0.
  - Launch suppressed that cycle; the current test is not marked failed.
  - abort_i in IDLE/DONE is ignored.
  - abort_i and start_i in the same cycle from DONE: start wins.
- Timer width: $clog2(TIMEOUT_CYCLES+1). Gap counter width: $clog2(GAP_CYCLES+1). Neither wraps.

Test Plan:
Common setup: NUM_TESTS=4, TIMEOUT_CYCLES=20, GAP_CYCLES=2.
1. enable=4'b1111, run-all; each channel returns done+pass 5 cycles after its start -> test_start_o pulses 0001, 0010, 0100, 1000, one cycle each, in order, separated by the 2-cycle gap; done_o=1, pass_o=1, ran_mask=1111, fail_mask=0000.
2. enable=4'b1010 -> start pulses only on bits 1 and 3; ran_mask=1010; pass_o=1. Then enable=0000 -> done_o=1, pass_o=0, ran_mask=0000.
3. Channel 2 never asserts done, run-all -> its WAIT lasts exactly 20 cycles; timeout_mask=0100, fail_mask=0100; channel 3 still launched; pass_o=0.
4. stop_on_fail=1; channel 1 returns done with pass=0 -> DONE directly from WAIT; ran_mask=0011, fail_mask=0010; no pulses on bits 2 or 3.
5. abort_i in cycle 3 of channel 1's WAIT -> done_o=1 next cycle, aborted_o=1, pass_o=0, ran_mask=0011; start_i pulsed mid-run is ignored. Separately, rst mid-run -> all outputs 0 and IDLE next cycle.
6. Channel 0 asserts done+pass in its 20th WAIT cycle (timeout cycle) -> counted as pass, timeout_mask bit 0 stays 0. test_done_i[3] pulsed during channel 0's WAIT -> ignored; channel 3 is still launched and waited on later.
